// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types for the instruction fetch controller: FSM encoding, fetch entry record, buffer depth.
// Buffer depth follows INST_BUF_EN (4-entry FIFO when defined, single holding register otherwise).
package inst_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] exc;
  } fetch_entry_t;

`ifdef INST_BUF_EN
  localparam int FETCH_BUF_DEPTH = 4;
`else
  localparam int FETCH_BUF_DEPTH = 1;
`endif

  localparam int FETCH_CNT_W = $clog2(FETCH_BUF_DEPTH + 1);
  localparam logic [31:0] EXC_NONE = 32'h0;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch controller bundle: PC offer, I-cache request/response, redirect/stall and decode-side head entry.
// master drives the PC/cache/decode side, slave is the fetch controller.
interface inst_fetch_ctrl_if;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic [31:0] exception_type_i;
  logic        inst_ren_o;
  logic [31:0] inst_addr_o;
  logic        inst_ok_i;
  logic [31:0] inst_i;
  logic        flush_i;
  logic        id_stall_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic [31:0] exception_type_o;
  logic        inst_valid_o;
  logic        fetch_stall_o;

  modport master (
    output pc_i, pc_valid_i, exception_type_i, inst_ok_i, inst_i, flush_i, id_stall_i,
    input  pc_ready_o, inst_ren_o, inst_addr_o, pc_o, inst_o, exception_type_o,
           inst_valid_o, fetch_stall_o
  );

  modport slave (
    input  pc_i, pc_valid_i, exception_type_i, inst_ok_i, inst_i, flush_i, id_stall_i,
    output pc_ready_o, inst_ren_o, inst_addr_o, pc_o, inst_o, exception_type_o,
           inst_valid_o, fetch_stall_o
  );
endinterface

// File: rtl/inst_fetch_buf.sv
// Fetch entry FIFO with wrap-around pointers; two ordered write ports (a older than b), one read port.
// Latency: a push is visible at the head the next cycle. Backpressure: caller must not push past DEPTH.
// Flush empties it in one cycle; a pop on empty is ignored.
module inst_fetch_buf
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = FETCH_BUF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  input  logic                         i_push_a,
  input  fetch_entry_t                 i_push_a_dat,
  input  logic                         i_push_b,
  input  fetch_entry_t                 i_push_b_dat,
  input  logic                         i_pop,
  output fetch_entry_t                 o_head_dat,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   w_wr_nxt, w_rd_nxt, w_b_slot;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    w_pop       = i_pop & ~o_empty;
    w_b_slot    = i_push_a ? ptr_inc(r_wr_ptr) : r_wr_ptr;
    w_wr_nxt    = r_wr_ptr;
    if (i_push_a) w_wr_nxt = ptr_inc(w_wr_nxt);
    if (i_push_b) w_wr_nxt = ptr_inc(w_wr_nxt);
    w_rd_nxt    = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    w_count_nxt = r_count + CNT_W'(i_push_a) + CNT_W'(i_push_b) - CNT_W'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // Storage needs no reset: the head is only meaningful while count is nonzero.
  always_ff @(posedge clk) begin
    if (!rst && !i_flush) begin
      if (i_push_a) r_mem[r_wr_ptr] <= i_push_a_dat;
      if (i_push_b) r_mem[w_b_slot] <= i_push_b_dat;
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: accepts PCs, issues one I-cache read at a time, queues entries for decode.
// Latency: entry visible to decode the cycle after cache completion (or after accepting a faulted PC).
// Backpressure: pc_ready_o only when a buffer slot is reserved; INST_BUF_EN selects 4-deep vs 1-deep buffer.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  inst_fetch_ctrl_if.slave   bus
);
  fetch_state_t              r_state;
  logic                      r_ren;
  logic [31:0]               r_addr;

  fetch_entry_t              w_head, w_cmpl_dat, w_fault_dat;
  logic                      w_full, w_empty, w_room2;
  logic [FETCH_CNT_W-1:0]    w_count;
  logic                      w_in_idle, w_in_req, w_pc_ready, w_accept, w_fault;
  logic                      w_fetch, w_cmpl, w_push_fault, w_valid, w_pop;

  assign w_in_idle    = (r_state == ST_IDLE);
  assign w_in_req     = (r_state == ST_REQ);
  assign w_room2      = (32'(w_count) + 32'd2) <= 32'(FETCH_BUF_DEPTH);
  // A new PC is taken only when a slot is free for it on top of the completing read.
  assign w_pc_ready   = ~bus.flush_i &
                        ((w_in_idle & ~w_full) | (w_in_req & bus.inst_ok_i & w_room2));
  assign w_accept     = bus.pc_valid_i & w_pc_ready;
  assign w_fault      = (bus.exception_type_i != EXC_NONE);
  assign w_fetch      = w_accept & ~w_fault;
  assign w_push_fault = w_accept & w_fault;
  assign w_cmpl       = w_in_req & bus.inst_ok_i & ~bus.flush_i;
  assign w_valid      = ~w_empty;
  assign w_pop        = w_valid & ~bus.id_stall_i & ~bus.flush_i;

  always_comb begin
    w_cmpl_dat.pc    = r_addr;
    w_cmpl_dat.inst  = bus.inst_i;
    w_cmpl_dat.exc   = EXC_NONE;
    w_fault_dat.pc   = bus.pc_i;
    w_fault_dat.inst = 32'h0;
    w_fault_dat.exc  = bus.exception_type_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ren   <= 1'b0;
      r_addr  <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fetch) begin
            r_state <= ST_REQ;
            r_ren   <= 1'b1;
            r_addr  <= bus.pc_i;
          end
        end
        ST_REQ: begin
          if (bus.flush_i) begin
            if (bus.inst_ok_i) begin
              r_state <= ST_IDLE;
              r_ren   <= 1'b0;
            end else begin
              r_state <= ST_DISCARD;
            end
          end else if (bus.inst_ok_i) begin
            if (w_fetch) begin
              r_addr  <= bus.pc_i;
            end else begin
              r_state <= ST_IDLE;
              r_ren   <= 1'b0;
            end
          end
        end
        ST_DISCARD: begin
          if (bus.inst_ok_i) begin
            r_state <= ST_IDLE;
            r_ren   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ren   <= 1'b0;
        end
      endcase
    end
  end

  inst_fetch_buf #(.DEPTH(FETCH_BUF_DEPTH)) u_buf (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (bus.flush_i),
    .i_push_a     (w_cmpl),
    .i_push_a_dat (w_cmpl_dat),
    .i_push_b     (w_push_fault),
    .i_push_b_dat (w_fault_dat),
    .i_pop        (w_pop),
    .o_head_dat   (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count)
  );

  assign bus.pc_ready_o       = w_pc_ready;
  assign bus.inst_ren_o       = r_ren;
  assign bus.inst_addr_o      = r_addr;
  assign bus.inst_valid_o     = w_valid;
  assign bus.pc_o             = w_valid ? w_head.pc   : 32'h0;
  assign bus.inst_o           = w_valid ? w_head.inst : 32'h0;
  assign bus.exception_type_o = w_valid ? w_head.exc  : 32'h0;
  assign bus.fetch_stall_o    = w_empty & r_ren;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed scenarios plus random traffic against a queue-based reference model.
module tb_inst_fetch_ctrl;
  import inst_fetch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_ctrl_if bus ();

  inst_fetch_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected decode-side entries, plus whether a read is in flight and whether it is doomed.
  fetch_entry_t m_q[$];
  bit           m_busy;
  bit           m_drop;
  logic [31:0]  m_addr;
  bit           last_acc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit pv, input logic [31:0] pc, input logic [31:0] exc,
                      input bit ok, input logic [31:0] inst, input bit fl, input bit st);
    bit           exp_rdy, exp_vld;
    int           free;
    fetch_entry_t head, e;
    @(negedge clk);
    bus.pc_valid_i       = pv;
    bus.pc_i             = pc;
    bus.exception_type_i = exc;
    bus.inst_ok_i        = ok;
    bus.inst_i           = inst;
    bus.flush_i          = fl;
    bus.id_stall_i       = st;
    #1;
    exp_vld = (m_q.size() != 0);
    free    = FETCH_BUF_DEPTH - m_q.size();
    exp_rdy = !fl && ((!m_busy && free >= 1) || (m_busy && !m_drop && ok && free >= 2));
    head    = '0;
    if (exp_vld) head = m_q[0];
    check_eq("pc_ready", bus.pc_ready_o, exp_rdy);
    check_eq("inst_ren", bus.inst_ren_o, m_busy);
    if (m_busy) check_eq("inst_addr", bus.inst_addr_o, m_addr);
    check_eq("inst_valid", bus.inst_valid_o, exp_vld);
    check_eq("pc_o", bus.pc_o, head.pc);
    check_eq("inst_o", bus.inst_o, head.inst);
    check_eq("exc_o", bus.exception_type_o, head.exc);
    check_eq("fetch_stall", bus.fetch_stall_o, !exp_vld && m_busy);

    last_acc = pv && exp_rdy;
    if (fl) begin
      m_q.delete();
    end else begin
      if (exp_vld && !st) void'(m_q.pop_front());
      if (m_busy && !m_drop && ok) begin
        e.pc = m_addr; e.inst = inst; e.exc = EXC_NONE;
        m_q.push_back(e);
      end
      if (last_acc && exc != EXC_NONE) begin
        e.pc = pc; e.inst = 32'h0; e.exc = exc;
        m_q.push_back(e);
      end
    end
    if (m_busy && ok) begin
      m_busy = 0;
      m_drop = 0;
    end else if (m_busy && fl) begin
      m_drop = 1;
    end
    if (last_acc && exc == EXC_NONE) begin
      m_busy = 1;
      m_drop = 0;
      m_addr = pc;
    end
  endtask

  task automatic idle(input bit st);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, st);
  endtask

  // Reset is applied while a PC and a completion are offered; the completion right after reset must be ignored.
  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    bus.pc_valid_i = 1'b1;
    bus.inst_ok_i  = 1'b1;
    bus.flush_i    = 1'b0;
    bus.id_stall_i = 1'b0;
    @(negedge clk);
    rst            = 1'b0;
    bus.pc_valid_i = 1'b0;
    bus.inst_ok_i  = 1'b1;
    #1;
    check_eq("rst_ren", bus.inst_ren_o, 32'h0);
    check_eq("rst_addr", bus.inst_addr_o, 32'h0);
    check_eq("rst_valid", bus.inst_valid_o, 32'h0);
    check_eq("rst_pc", bus.pc_o, 32'h0);
    check_eq("rst_inst", bus.inst_o, 32'h0);
    check_eq("rst_exc", bus.exception_type_o, 32'h0);
    check_eq("rst_stall", bus.fetch_stall_o, 32'h0);
    m_q.delete();
    m_busy = 0;
    m_drop = 0;
    m_addr = 32'h0;
  endtask

  initial begin
    logic [31:0] r;
    int          n;
    rst                  = 1'b1;
    bus.pc_valid_i       = 1'b0;
    bus.pc_i             = 32'h0;
    bus.exception_type_i = 32'h0;
    bus.inst_ok_i        = 1'b0;
    bus.inst_i           = 32'h0;
    bus.flush_i          = 1'b0;
    bus.id_stall_i       = 1'b0;
    do_reset();

    // Single fetch, completion on the second read cycle.
    step(1'b1, 32'hBFC00000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("f1_ready", bus.pc_ready_o, 32'h1);
    idle(1'b0);
    check_eq("f1_ren", bus.inst_ren_o, 32'h1);
    check_eq("f1_addr", bus.inst_addr_o, 32'hBFC00000);
    check_eq("f1_stall", bus.fetch_stall_o, 32'h1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h3C1D8000, 1'b0, 1'b0);
    check_eq("f1_novalid", bus.inst_valid_o, 32'h0);
    idle(1'b1);
    check_eq("f1_valid", bus.inst_valid_o, 32'h1);
    check_eq("f1_pc", bus.pc_o, 32'hBFC00000);
    check_eq("f1_inst", bus.inst_o, 32'h3C1D8000);
    check_eq("f1_exc", bus.exception_type_o, 32'h0);
    check_eq("f1_ren_off", bus.inst_ren_o, 32'h0);
    idle(1'b0);

    // Flush while the read is outstanding: the late data must be dropped.
    step(1'b1, 32'h80000000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h80000040, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("disc_ren", bus.inst_ren_o, 32'h1);
    check_eq("disc_addr", bus.inst_addr_o, 32'h80000000);
    check_eq("disc_ready", bus.pc_ready_o, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h12345678, 1'b0, 1'b0);
    idle(1'b0);
    check_eq("disc_idle_ren", bus.inst_ren_o, 32'h0);
    check_eq("disc_valid", bus.inst_valid_o, 32'h0);
    check_eq("disc_inst", bus.inst_o, 32'h0);
    check_eq("disc_idle_ready", bus.pc_ready_o, 32'h1);

    // Faulted PC bypasses the cache.
    step(1'b1, 32'hBFC00001, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("flt_ready", bus.pc_ready_o, 32'h1);
    idle(1'b1);
    check_eq("flt_ren", bus.inst_ren_o, 32'h0);
    check_eq("flt_valid", bus.inst_valid_o, 32'h1);
    check_eq("flt_pc", bus.pc_o, 32'hBFC00001);
    check_eq("flt_inst", bus.inst_o, 32'h0);
    check_eq("flt_exc", bus.exception_type_o, 32'h4);
    idle(1'b0);

    // Flush coinciding with completion, then reset while a read is outstanding.
    step(1'b1, 32'h80001000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    idle(1'b0);
    check_eq("fo_ren", bus.inst_ren_o, 32'h0);
    check_eq("fo_valid", bus.inst_valid_o, 32'h0);
    step(1'b1, 32'h80002000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    check_eq("rq_ren", bus.inst_ren_o, 32'h1);
    do_reset();
    idle(1'b0);

`ifdef INST_BUF_EN
    // Back-to-back fetch into a stalled decode fills exactly four entries.
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 32'h1000 + 32'(4 * n), 32'h0, 1'b1, 32'hC0DE0000 + 32'(k), 1'b0, 1'b1);
      if (last_acc) n++;
    end
    check_eq("full_ready", bus.pc_ready_o, 32'h0);
    check_eq("full_valid", bus.inst_valid_o, 32'h1);
    for (int k = 0; k < 4; k++) begin
      idle(1'b0);
      check_eq("drain_valid", bus.inst_valid_o, 32'h1);
      check_eq("drain_pc", bus.pc_o, 32'h1000 + 32'(4 * k));
    end
    idle(1'b0);
    check_eq("drain_empty", bus.inst_valid_o, 32'h0);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        r = $urandom;
        step($urandom_range(0, 9) < 6,
             r & 32'hFFFF_FFFC,
             ($urandom_range(0, 4) == 0) ? 32'($urandom_range(1, 31)) : 32'h0,
             $urandom_range(0, 1) == 1,
             $urandom,
             $urandom_range(0, 19) == 0,
             $urandom_range(0, 9) < 3);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on its rising edge.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 pc_i / pc_valid_i / pc_ready_o  in/in/out  32/1/1  fetch PC offer from PC stage; accepted on valid&ready.
REQ-004 exception_type_i  input  32  fetch-side exception code for pc_i; nonzero means faulted.
REQ-005 inst_ren_o / inst_addr_o  output  1/32  I-cache read request and address.
REQ-006 inst_ok_i / inst_i  input  1/32  I-cache completion pulse and returned instruction.
REQ-007 flush_i  input  1  branch/exception redirect; kills all fetch state.
REQ-008 id_stall_i  input  1  decode cannot accept this cycle.
REQ-009 pc_o / inst_o / exception_type_o / inst_valid_o  output  32/32/32/1  head entry toward decode.
REQ-010 fetch_stall_o  output  1  high when no entry is valid and a request is outstanding.

Function
REQ-011 FSM states SHALL be IDLE, REQ (one read outstanding) and DISCARD (outstanding read whose data is dropped).
REQ-012 A cache transaction SHALL complete in a cycle with inst_ren_o&inst_ok_i; inst_ok_i may arrive in the first ren cycle; at most one outstanding.
REQ-013 inst_ren_o SHALL be high in REQ and DISCARD with inst_addr_o held stable until completion.
REQ-014 pc_ready_o SHALL be ~flush_i & ((IDLE & free>=1) | (REQ & inst_ok_i & free>=2)); free = empty entries before this cycle's drain.
REQ-015 An accepted pc with exception_type_i==0 SHALL enter REQ next cycle with inst_addr_o=pc_i.
REQ-016 An accepted pc with exception_type_i!=0 SHALL issue no cache read; an entry {pc, inst=0, exc} is written next cycle; FSM stays IDLE.
REQ-017 On completion in REQ, {pc, inst_i, exc=0} SHALL be written; inst_valid_o at earliest the following cycle (1-cycle latency).
REQ-018 Completion in REQ without a new acceptance SHALL return to IDLE; with one, stays REQ with the new address.
REQ-019 Outputs SHALL present the oldest entry; an entry drains in any cycle with inst_valid_o & ~id_stall_i & ~flush_i.
REQ-020 flush_i SHALL empty all entries (inst_valid_o=0 next cycle) and block acceptance that cycle.
REQ-021 flush_i in REQ without inst_ok_i SHALL go to DISCARD; with inst_ok_i, data dropped, go IDLE.
REQ-022 DISCARD SHALL drop data on completion and go IDLE; pc_ready_o=0 throughout DISCARD; flush in DISCARD stays DISCARD.
REQ-023 Simultaneous write and drain SHALL both take effect; entry count never exceeds DEPTH and never underflows.

Reset
REQ-024 rst SHALL force IDLE, empty buffer, inst_ren_o=0, inst_addr_o=0, inst_valid_o=0, pc_o=inst_o=exception_type_o=0, fetch_stall_o=0.
REQ-025 rst mid-transaction SHALL abandon the read; an inst_ok_i arriving after reset in IDLE SHALL be ignored.

Configuration
REQ-026 With INST_BUF_EN defined, the buffer SHALL be a 4-entry FIFO with wrap-around pointers (DEPTH=4), allowing back-to-back fetch.
REQ-027 Without INST_BUF_EN, the buffer SHALL be a single holding register (DEPTH=1); throughput at most one instruction per two cycles.

Structure
REQ-028 Shared package SHALL hold the FSM state encoding, the fetch entry record (pc, inst, exc: 96 bits), the FIFO depth constant and EXC_NONE=32'h0.
REQ-029 The buffer SHALL be one sub-module inst_fetch_buf (push/pop/flush, full/empty, count), parameterized by depth.

Verification
REQ-030 Single fetch: pc=0xBFC00000, ok on 2nd ren cycle, inst_i=0x3C1D8000 -> inst_valid_o next cycle with pc_o=0xBFC00000, inst_o=0x3C1D8000.
REQ-031 Flush in REQ before ok -> DISCARD, ren held at old address, ok data 0x12345678 never on inst_o, then IDLE with pc_ready_o=1.
REQ-032 Faulted pc 0xBFC00001, exception_type_i=0x4 -> no inst_ren_o, entry with inst_o=0, exception_type_o=0x4 next cycle.
REQ-033 INST_BUF_EN, id_stall_i=1, ok every cycle -> exactly 4 entries, pc_ready_o drops, release drains in order with no loss.
REQ-034 Simultaneous flush_i and inst_ok_i in REQ -> data dropped, IDLE next cycle, inst_valid_o=0; rst during REQ -> all REQ-024 values next cycle.
